sample_bank_reader: RTL and testbench

- Read side of the 8-entry reaction-time sample bank.
- On request, reads every entry through a synchronous read port, one per cycle, and accumulates the values.
- Divides the total by DEPTH to form the average, saturates it to 9999, and converts it to four BCD digits with an iterative double-dabble.
- Feeds the SSD digit mux with a done pulse and held digits. It replaces the combinational sum/divide/BCD path.

---
 rtl/sample_bank_reader.sv | 165 ++++++++++++++++
 tb/tb_sample_bank_reader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sample_bank_reader.sv
// Read side of the reaction-time sample bank. It walks every entry through
// the synchronous read port and sums the values. It then divides the sum by
// DEPTH with a shift, clamps the result to 9999, and converts it to four BCD
// digits with a multi-cycle double-dabble. Results are held until the next
// operation completes.
module sample_bank_reader #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] avg_bin,
    output logic [3:0]        bcd_thousand,
    output logic [3:0]        bcd_hundred,
    output logic [3:0]        bcd_ten,
    output logic [3:0]        bcd_one
);

    localparam int ACC_W = DATA_W + ADDR_W;
    localparam int SH_W  = 16 + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] SAT_VAL = DATA_W'(9999);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DIV,
        S_BCD,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  idx_reg;
    logic               vld_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [SH_W-1:0]    sh_reg;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [DATA_W-1:0]  avg_pend_reg;

    logic [ACC_W-1:0]   quot_full;
    logic [DATA_W-1:0]  quot_sat;
    logic [15:0]        adj;
    logic [SH_W-1:0]    sh_shift;

    // Division by a power-of-two depth is a plain shift; then clamp to 4 digits.
    assign quot_full = acc_reg >> ADDR_W;
    assign quot_sat  = (quot_full > ACC_W'(9999)) ? SAT_VAL : quot_full[DATA_W-1:0];

    // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dd_adj
            assign adj[gi*4 +: 4] = (sh_reg[DATA_W + gi*4 +: 4] >= 4'd5)
                                    ? sh_reg[DATA_W + gi*4 +: 4] + 4'd3
                                    : sh_reg[DATA_W + gi*4 +: 4];
        end
    endgenerate

    // The top digit can never overflow because the input is clamped to 9999.
    assign sh_shift = SH_W'({adj, sh_reg[DATA_W-1:0]} << 1);

    assign rd_addr = idx_reg;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic and control strobes.
    always_comb begin
        state_next = state_reg;
        rd_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req) state_next = S_READ;
            end
            S_READ: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (idx_reg == ADDR_W'(DEPTH - 1)) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy       = 1'b1;
                state_next = S_DIV;
            end
            S_DIV: begin
                busy       = 1'b1;
                state_next = S_BCD;
            end
            S_BCD: begin
                busy = 1'b1;
                if (bit_cnt_reg == CNT_W'(DATA_W - 1)) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: address walk, delayed valid, accumulate, divide, convert, publish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg      <= '0;
            vld_reg      <= 1'b0;
            acc_reg      <= '0;
            sh_reg       <= '0;
            bit_cnt_reg  <= '0;
            avg_pend_reg <= '0;
            avg_bin      <= '0;
            bcd_thousand <= '0;
            bcd_hundred  <= '0;
            bcd_ten      <= '0;
            bcd_one      <= '0;
        end else begin
            // Read data returns one cycle after the strobe.
            vld_reg <= rd_en;
            if (vld_reg) acc_reg <= acc_reg + ACC_W'(rd_data);

            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        idx_reg     <= '0;
                        acc_reg     <= '0;
                        bit_cnt_reg <= '0;
                    end
                end
                S_READ: begin
                    // Stops at the last entry so rd_addr holds afterwards.
                    if (idx_reg != ADDR_W'(DEPTH - 1)) idx_reg <= idx_reg + 1'b1;
                end
                S_DIV: begin
                    sh_reg       <= {16'b0, quot_sat};
                    avg_pend_reg <= quot_sat;
                    bit_cnt_reg  <= '0;
                end
                S_BCD: begin
                    sh_reg      <= sh_shift;
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    // Results become visible together with the done pulse.
                    if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
                        avg_bin      <= avg_pend_reg;
                        bcd_thousand <= sh_shift[SH_W-1  -: 4];
                        bcd_hundred  <= sh_shift[SH_W-5  -: 4];
                        bcd_ten      <= sh_shift[SH_W-9  -: 4];
                        bcd_one      <= sh_shift[SH_W-13 -: 4];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_bank_reader.sv
// Bench for sample_bank_reader: a synchronous-read bank model feeds the DUT.
// Expected results come from plain integer arithmetic on the bank contents.
module tb_sample_bank_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [13:0] rd_data = '0;
    logic        busy;
    logic        done;
    logic [13:0] avg_bin;
    logic [3:0]  bcd_thousand, bcd_hundred, bcd_ten, bcd_one;

    logic [13:0] bank [8];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Bank with a registered read port.
    always @(posedge clk) if (rd_en) rd_data <= bank[rd_addr];

    sample_bank_reader dut (
        .clk(clk), .rst(rst), .req(req),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .avg_bin(avg_bin),
        .bcd_thousand(bcd_thousand), .bcd_hundred(bcd_hundred),
        .bcd_ten(bcd_ten), .bcd_one(bcd_one)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int ref_avg();
        int sum = 0;
        for (int i = 0; i < 8; i++) sum += int'(bank[i]);
        sum = sum / 8;
        return (sum > 9999) ? 9999 : sum;
    endfunction

    task automatic chk_outputs(input string tag, input int a);
        chk({tag, " avg_bin"},  32'(avg_bin),      32'(a));
        chk({tag, " thousand"}, 32'(bcd_thousand), 32'(a / 1000));
        chk({tag, " hundred"},  32'(bcd_hundred),  32'((a / 100) % 10));
        chk({tag, " ten"},      32'(bcd_ten),      32'((a / 10) % 10));
        chk({tag, " one"},      32'(bcd_one),      32'(a % 10));
        $display("op %s: bank avg %0d -> dut %0d digits %0d%0d%0d%0d",
                 tag, a, avg_bin, bcd_thousand, bcd_hundred, bcd_ten, bcd_one);
    endtask

    // mode 0: single request; 1: extra req pulses while busy;
    // 2: req held high for back-to-back; 3: async reset at T+15.
    task automatic run_op(input string tag, input int mode);
        int exp_avg = ref_avg();
        int limit = (mode == 2) ? 56 : 40;
        int ndone = 0, first_done = -1, second_done = -1;
        int bad_rd = 0, bad_busy = 0;
        logic exp_rd, exp_busy;
        int exp_addr;
        @(negedge clk) req = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= limit; k++) begin
            #1;
            if (mode != 3 || k < 15) begin
                exp_rd   = (k <= 8) || (mode == 2 && k >= 27 && k <= 34);
                exp_addr = (k <= 8) ? k - 1 : k - 27;
                exp_busy = (k <= 24) || (mode == 2 && k >= 27 && k <= 50);
                if (rd_en !== exp_rd) bad_rd++;
                if (exp_rd && rd_addr !== 3'(exp_addr)) bad_rd++;
                if (busy !== exp_busy) bad_busy++;
            end
            if (done === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
            if (mode == 3 && k == 15) begin
                #2 rst = 1'b0;
                #1;
                chk({tag, " rst busy"},    32'(busy),    0);
                chk({tag, " rst done"},    32'(done),    0);
                chk({tag, " rst rd_en"},   32'(rd_en),   0);
                chk({tag, " rst rd_addr"}, 32'(rd_addr), 0);
                chk_outputs({tag, " rst"}, 0);
            end
            @(negedge clk);
            case (mode)
                1: req = (k == 5 || k == 20);
                2: req = (k <= 26);
                3: begin req = 1'b0; if (k == 17) rst = 1'b1; end
                default: req = 1'b0;
            endcase
            @(posedge clk);
        end
        if (mode == 3) begin
            chk({tag, " no done"}, 32'(ndone), 0);
            chk_outputs({tag, " after rst"}, 0);
        end else begin
            chk({tag, " done cycle"}, 32'(first_done), 25);
            chk({tag, " done count"}, 32'(ndone), (mode == 2) ? 2 : 1);
            if (mode == 2) chk({tag, " 2nd done cycle"}, 32'(second_done), 51);
            chk({tag, " rd pattern errs"}, 32'(bad_rd), 0);
            chk({tag, " busy errs"}, 32'(bad_busy), 0);
            chk_outputs(tag, exp_avg);
        end
    endtask

    initial begin
        int nd, nr;
        rst = 1'b0;
        req = 1'b0;
        for (int i = 0; i < 8; i++) bank[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rd_en",   32'(rd_en),   0);
        chk("reset rd_addr", 32'(rd_addr), 0);
        chk("reset busy",    32'(busy),    0);
        chk("reset done",    32'(done),    0);
        chk_outputs("reset", 0);
        @(negedge clk) rst = 1'b1;

        // Idle with no request: nothing may happen.
        nd = 0; nr = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) nd++;
            if (rd_en !== 1'b0) nr++;
        end
        chk("idle done", 32'(nd), 0);
        chk("idle rd_en", 32'(nr), 0);
        chk_outputs("idle", 0);

        for (int i = 0; i < 8; i++) bank[i] = 14'd100;
        run_op("all100", 0);

        for (int i = 0; i < 8; i++) bank[i] = 14'(1000 * (i + 1));
        run_op("ramp", 0);
        run_op("ramp extra req", 1);

        for (int i = 0; i < 8; i++) bank[i] = (i == 0) ? 14'd7 : 14'd0;
        run_op("trunc", 0);

        for (int i = 0; i < 8; i++) bank[i] = 14'd9999;
        run_op("all9999", 0);

        for (int i = 0; i < 8; i++) bank[i] = 14'd16383;
        run_op("sat", 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) bank[i] = 14'($urandom_range(0, 16383));
            run_op($sformatf("rand%0d", r), 0);
        end

        for (int i = 0; i < 8; i++) bank[i] = 14'($urandom_range(0, 12000));
        run_op("held req", 2);

        for (int i = 0; i < 8; i++) bank[i] = 14'(500 + 37 * i);
        run_op("mid reset", 3);
        run_op("after reset", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
